// File: rtl/mem_cmd_decoder.sv
// mem_cmd_decoder
//
// Decodes an upstream memory command stream. Memory commands (READ,
// WRITE, REFRESH, MODE) are forwarded in order through a 2-entry buffer.
// PD_ENTER/PD_EXIT drive a small power-down handshake with an external
// power manager, and a per-cycle activity code is reported for that
// manager.
//
// Handshake semantics (both streams): a beat transfers on a rising edge
// where valid && ready are both high. The sender holds valid and its
// payload steady until the transfer. cmd_ready is a function of
// registered state only and never depends on cmd_valid or cmd_op.
//
// Ports
//   sys_clk              in   sole clock, rising edge
//   sys_rst_n            in   asynchronous active-low reset
//   cmd_valid/cmd_ready  in/out  upstream handshake
//   cmd_op[3:0]          in   opcode (0 NOP, 1 READ, 2 WRITE, 3 REFRESH,
//                             4 MODE, 5 PD_ENTER, 6 PD_EXIT, 7-15 illegal)
//   cmd_addr[ADDR_W-1:0] in   command address
//   out_valid/out_ready  out/in  downstream handshake
//   out_op[3:0]          out  buffered opcode at the head of the buffer
//   out_addr[ADDR_W-1:0] out  buffered address at the head of the buffer
//   cmd_decoded[3:0]     out  activity code (0 idle, 1-4 memory op,
//                             F first wake cycle)
//   enter_power_down     out  level power-down request
//   power_down_entered   in   power manager status, high while powered down
//   err_illegal          out  one-cycle pulse: illegal opcode or
//                             power-down entry timeout
//   fsm_state[1:0]       out  current FSM state (0 ACTIVE, 1 PD_REQ,
//                             2 POWER_DOWN, 3 WAKE) for observation

module mem_cmd_decoder #(
  parameter int ADDR_W     = 32,
  parameter int WAKE_LAT   = 8,     // legal 1..255
  parameter int PD_TIMEOUT = 2047   // legal 1..2047
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [ADDR_W-1:0] out_addr,

  output logic [3:0]        cmd_decoded,
  output logic              enter_power_down,
  input  logic              power_down_entered,
  output logic              err_illegal,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    ST_ACTIVE     = 2'd0,
    ST_PD_REQ     = 2'd1,
    ST_POWER_DOWN = 2'd2,
    ST_WAKE       = 2'd3
  } state_t;

  localparam logic [3:0] OP_READ     = 4'd1;
  localparam logic [3:0] OP_MODE     = 4'd4;
  localparam logic [3:0] OP_PD_ENTER = 4'd5;
  localparam logic [3:0] OP_PD_EXIT  = 4'd6;
  localparam logic [3:0] CODE_WAKE   = 4'hF;

  localparam logic [10:0] PD_LIMIT   = 11'(PD_TIMEOUT);
  localparam logic [7:0]  WAKE_LIMIT = 8'(WAKE_LAT);

  // --------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------
  state_t            state;
  state_t            state_next;
  logic [10:0]       pd_cnt;
  logic [10:0]       pd_cnt_next;
  logic [7:0]        wake_cnt;
  logic [7:0]        wake_cnt_next;
  logic [3:0]        decoded_next;
  logic              err_next;

  logic [3:0]        buf_op   [2];
  logic [ADDR_W-1:0] buf_addr [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              accept;
  logic              push;
  logic              pop;
  logic              is_mem_op;
  logic              is_illegal;

  // --------------------------------------------------------------------
  // Opcode classification and handshakes
  // --------------------------------------------------------------------
  assign is_mem_op  = (cmd_op >= OP_READ) && (cmd_op <= OP_MODE);
  assign is_illegal = (cmd_op > OP_PD_EXIT);

  assign cmd_ready = (state == ST_ACTIVE) && (count != 2'd2);
  assign accept    = cmd_valid && cmd_ready;

  // NOP, PD_ENTER, PD_EXIT and illegal opcodes are consumed without
  // touching the buffer.
  assign push      = accept && is_mem_op;

  // count is registered, so out_valid is a registered quantity.
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_op    = buf_op[rd_ptr];
  assign out_addr  = buf_addr[rd_ptr];

  assign fsm_state = state;

  // --------------------------------------------------------------------
  // FSM: next state, counters and registered-output next values
  // --------------------------------------------------------------------
  always_comb begin
    state_next       = state;
    pd_cnt_next      = pd_cnt;
    wake_cnt_next    = wake_cnt;
    decoded_next     = 4'd0;
    err_next         = 1'b0;
    enter_power_down = 1'b0;

    case (state)
      ST_ACTIVE: begin
        if (accept) begin
          if (is_mem_op) begin
            decoded_next = cmd_op;
          end else if (is_illegal) begin
            err_next = 1'b1;
          end else if (cmd_op == OP_PD_ENTER) begin
            state_next  = ST_PD_REQ;
            pd_cnt_next = 11'd0;
          end
        end
      end

      ST_PD_REQ: begin
        // The request is only raised once every buffered command has
        // drained; the timeout keeps running meanwhile.
        enter_power_down = (count == 2'd0);
        pd_cnt_next      = pd_cnt + 11'd1;
        if (power_down_entered) begin
          state_next = ST_POWER_DOWN;
        end else if (pd_cnt_next == PD_LIMIT) begin
          // Timeout wins over a simultaneous cmd_valid so that exactly
          // one error pulse is produced.
          state_next = ST_ACTIVE;
          err_next   = 1'b1;
        end else if (cmd_valid) begin
          // New traffic cancels the request; the command itself is
          // accepted once back in ACTIVE.
          state_next = ST_ACTIVE;
        end
      end

      ST_POWER_DOWN: begin
        enter_power_down = 1'b1;
        if (cmd_valid || !power_down_entered) begin
          state_next    = ST_WAKE;
          wake_cnt_next = 8'd0;
          // Registered, so the code is visible during the first WAKE
          // cycle only.
          decoded_next  = CODE_WAKE;
        end
      end

      ST_WAKE: begin
        // WAKE lasts exactly WAKE_LAT cycles.
        wake_cnt_next = wake_cnt + 8'd1;
        if (wake_cnt_next == WAKE_LIMIT) begin
          state_next = ST_ACTIVE;
        end
      end

      default: begin
        state_next = ST_ACTIVE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_ACTIVE;
      pd_cnt      <= 11'd0;
      wake_cnt    <= 8'd0;
      cmd_decoded <= 4'd0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_next;
      pd_cnt      <= pd_cnt_next;
      wake_cnt    <= wake_cnt_next;
      cmd_decoded <= decoded_next;
      err_illegal <= err_next;
    end
  end

  // --------------------------------------------------------------------
  // 2-entry in-order command buffer. Push is blocked while full
  // (cmd_ready low), so a simultaneous push and pop only happens with
  // one entry present and leaves the count unchanged.
  // --------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_op[i]   <= 4'd0;
        buf_addr[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_op[wr_ptr]   <= cmd_op;
        buf_addr[wr_ptr] <= cmd_addr;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_decoder.sv
// tb_mem_cmd_decoder
//
// Directed bench for mem_cmd_decoder (WAKE_LAT = 8, PD_TIMEOUT = 20).
// Inputs change 1 time unit after a rising edge; outputs are checked at
// that point or on the falling edge. Every output transfer is also
// compared against a queue of expected {op, addr} beats.

module tb_mem_cmd_decoder;

  localparam int ADDR_W     = 32;
  localparam int WAKE_LAT   = 8;
  localparam int PD_TIMEOUT = 20;

  localparam logic [1:0] S_ACTIVE     = 2'd0;
  localparam logic [1:0] S_PD_REQ     = 2'd1;
  localparam logic [1:0] S_POWER_DOWN = 2'd2;
  localparam logic [1:0] S_WAKE       = 2'd3;

  // ---------------- clock / reset ----------------
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_op    = 4'd0;
  logic [ADDR_W-1:0] cmd_addr  = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        out_op;
  logic [ADDR_W-1:0] out_addr;
  logic [3:0]        cmd_decoded;
  logic              enter_power_down;
  logic              power_down_entered = 1'b0;
  logic              err_illegal;
  logic [1:0]        fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] exp_q[$];

  mem_cmd_decoder #(
    .ADDR_W    (ADDR_W),
    .WAKE_LAT  (WAKE_LAT),
    .PD_TIMEOUT(PD_TIMEOUT)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_addr          (cmd_addr),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_op            (out_op),
    .out_addr          (out_addr),
    .cmd_decoded       (cmd_decoded),
    .enter_power_down  (enter_power_down),
    .power_down_entered(power_down_entered),
    .err_illegal       (err_illegal),
    .fsm_state         (fsm_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [ADDR_W-1:0] addr);
    cmd_valid = v;
    cmd_op    = op;
    cmd_addr  = addr;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge sys_clk) begin
    if (sys_rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", {28'd0, out_op, out_addr}, 64'hDEAD);
      end else begin
        check("sb_beat", {28'd0, out_op, out_addr}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int w;

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_cmd_decoded", cmd_decoded, 0);
    check("rst_enter_pd", enter_power_down, 0);
    check("rst_err", err_illegal, 0);
    check("rst_state", fsm_state, S_ACTIVE);
    sys_rst_n = 1'b1;
    check("rel_cmd_ready", cmd_ready, 1);

    // READ 0x100 then WRITE 0x200 back to back, out_ready high
    out_ready = 1'b1;
    drive(1, 4'd1, 32'h100); exp_q.push_back({4'd1, 32'h100});
    tick();
    check("a_valid_1", out_valid, 1);
    check("a_op_1", out_op, 1);
    check("a_addr_1", out_addr, 32'h100);
    check("a_dec_1", cmd_decoded, 1);
    drive(1, 4'd2, 32'h200); exp_q.push_back({4'd2, 32'h200});
    tick();
    check("a_valid_2", out_valid, 1);
    check("a_op_2", out_op, 2);
    check("a_addr_2", out_addr, 32'h200);
    check("a_dec_2", cmd_decoded, 2);
    drive(0, 4'd0, 32'h0);
    tick();
    check("a_valid_drained", out_valid, 0);
    check("a_dec_idle", cmd_decoded, 0);

    // Backpressure: three READs with out_ready low
    out_ready = 1'b0;
    drive(1, 4'd1, 32'h10); exp_q.push_back({4'd1, 32'h10});
    tick();
    check("b_ready_after_1", cmd_ready, 1);
    drive(1, 4'd1, 32'h11); exp_q.push_back({4'd1, 32'h11});
    tick();
    check("b_ready_full", cmd_ready, 0);
    check("b_head_addr", out_addr, 32'h10);
    drive(1, 4'd1, 32'h12); exp_q.push_back({4'd1, 32'h12});
    tick();
    check("b_ready_still_full", cmd_ready, 0);
    check("b_dec_blocked", cmd_decoded, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b_ready_after_pop", cmd_ready, 1);
    check("b_head_after_pop", out_addr, 32'h11);
    tick();
    drive(0, 4'd0, 32'h0);
    check("b_third_dec", cmd_decoded, 1);
    check("b_full_again", cmd_ready, 0);
    out_ready = 1'b1;
    tick();
    check("b_head_last", out_addr, 32'h12);
    tick();
    check("b_drained", out_valid, 0);

    // Illegal opcode, NOP, REFRESH, MODE, PD_EXIT
    drive(1, 4'd9, 32'h90);
    tick();
    check("c_err_pulse", err_illegal, 1);
    check("c_err_dec", cmd_decoded, 0);
    check("c_err_no_buf", out_valid, 0);
    drive(1, 4'd0, 32'h0);
    tick();
    check("c_err_one_cycle", err_illegal, 0);
    check("c_nop_dec", cmd_decoded, 0);
    check("c_nop_no_buf", out_valid, 0);
    drive(1, 4'd3, 32'h30); exp_q.push_back({4'd3, 32'h30});
    tick();
    check("c_refresh_dec", cmd_decoded, 3);
    check("c_refresh_op", out_op, 3);
    drive(1, 4'd4, 32'h40); exp_q.push_back({4'd4, 32'h40});
    tick();
    check("c_mode_dec", cmd_decoded, 4);
    check("c_mode_op", out_op, 4);
    drive(1, 4'd6, 32'h60);
    tick();
    check("c_pdexit_dec", cmd_decoded, 0);
    check("c_pdexit_state", fsm_state, S_ACTIVE);
    drive(0, 4'd0, 32'h0);
    tick();
    check("c_drained", out_valid, 0);

    // Power-down entry timeout
    drive(1, 4'd5, 32'h0);
    tick();
    drive(0, 4'd0, 32'h0);
    check("d_state_pdreq", fsm_state, S_PD_REQ);
    check("d_ready_low", cmd_ready, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!enter_power_down) break;
      n++;
      tick();
    end
    check("d_request_cycles", 64'(n), 64'(PD_TIMEOUT));
    check("d_back_active", fsm_state, S_ACTIVE);
    check("d_timeout_err", err_illegal, 1);
    tick();
    check("d_err_one_cycle", err_illegal, 0);

    // cmd_valid cancels a pending power-down request
    drive(1, 4'd5, 32'h0);
    tick();
    check("e_enter_pd", enter_power_down, 1);
    drive(1, 4'd0, 32'h0);
    tick();
    check("e_cancel_state", fsm_state, S_ACTIVE);
    check("e_cancel_pd_low", enter_power_down, 0);
    check("e_cancel_no_err", err_illegal, 0);
    drive(0, 4'd0, 32'h0);
    tick();

    // Full power-down and wake sequence
    drive(1, 4'd5, 32'h0);
    tick();
    drive(0, 4'd0, 32'h0);
    repeat (4) tick();
    power_down_entered = 1'b1;
    tick();
    check("f_state_pd", fsm_state, S_POWER_DOWN);
    check("f_pd_req_high", enter_power_down, 1);
    check("f_ready_low", cmd_ready, 0);
    repeat (4) tick();
    drive(1, 4'd1, 32'h300);
    check("f_ready_low_offer", cmd_ready, 0);
    tick();
    w = 0;
    for (int i = 0; i < 50; i++) begin
      if (fsm_state != S_WAKE) break;
      w++;
      if (w == 1) check("f_wake_code", cmd_decoded, 4'hF);
      if (w == 2) check("f_wake_code_once", cmd_decoded, 0);
      check("f_wake_pd_low", enter_power_down, 0);
      tick();
    end
    check("f_wake_cycles", 64'(w), 64'(WAKE_LAT));
    check("f_active_ready", cmd_ready, 1);
    check("f_not_yet_buffered", out_valid, 0);
    exp_q.push_back({4'd1, 32'h300});
    tick();
    drive(0, 4'd0, 32'h0);
    power_down_entered = 1'b0;
    check("f_read_valid", out_valid, 1);
    check("f_read_addr", out_addr, 32'h300);
    check("f_read_dec", cmd_decoded, 1);
    tick();

    // Asynchronous reset while powered down with a buffered command
    out_ready = 1'b0;
    drive(1, 4'd1, 32'h400);
    tick();
    drive(1, 4'd5, 32'h0);
    tick();
    drive(0, 4'd0, 32'h0);
    check("g_pdreq_buffered", fsm_state, S_PD_REQ);
    check("g_no_req_while_busy", enter_power_down, 0);
    power_down_entered = 1'b1;
    tick();
    check("g_state_pd", fsm_state, S_POWER_DOWN);
    check("g_buffered", out_valid, 1);
    #3 sys_rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("g_async_state", fsm_state, S_ACTIVE);
    check("g_async_out_valid", out_valid, 0);
    check("g_async_enter_pd", enter_power_down, 0);
    check("g_async_dec", cmd_decoded, 0);
    check("g_async_err", err_illegal, 0);
    tick();
    power_down_entered = 1'b0;
    sys_rst_n = 1'b1;
    check("g_release_ready", cmd_ready, 1);
    check("g_release_empty", out_valid, 0);

    // Asynchronous reset in ACTIVE with a full buffer
    drive(1, 4'd1, 32'h500);
    tick();
    drive(1, 4'd2, 32'h501);
    tick();
    drive(0, 4'd0, 32'h0);
    check("h_full", cmd_ready, 0);
    #3 sys_rst_n = 1'b0;
    #1;
    check("h_async_out_valid", out_valid, 0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    check("h_empty_after", out_valid, 0);
    check("h_ready_after", cmd_ready, 1);

    check("sb_queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
